// File: rtl/di_queue_pkg.sv
// Shared types for the decoded-instruction path: the decoder output record and
// the queue's fault-hold state.
package C;

  localparam int unsigned DI_ID_W = 20;

  typedef struct packed {
    logic               valid;
    logic               fault;
    logic [DI_ID_W-1:0] id;
    logic [31:0]        payload;
  } di_t;

  typedef enum logic {
    DIQ_RUN,
    DIQ_HOLD
  } diq_state_t;

endpackage

// File: rtl/di_queue_fifo_ptrs.sv
// Read/write pointers and occupancy for a power-of-two circular buffer.
module fifo_ptrs #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  // Pointer and count update; clear behaves like reset. Pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Status flags derived from occupancy.
  always_comb begin
    full  = (count == FULL_CNT);
    empty = (count == '0);
  end

endmodule

// File: rtl/di_queue.sv
// In-order buffer between the dynamic decoder and issue. Stops accepting after
// a faulting entry until flushed, and flags breaks in id continuity.
module di_queue
  import C::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ID_W  = DI_ID_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  di_t                    di_i,
  output logic                   di_i_ready_o,
  output di_t                    di_o,
  input  logic                   di_o_ready_i,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   fault_hold_o,
  output logic                   seq_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  diq_state_t    state_q;
  diq_state_t    state_d;

  di_t           mem [DEPTH];

  logic [ID_W-1:0] exp_id;
  logic            resync;

  // Flush wins over any transfer presented in the same cycle.
  always_comb begin
    push = di_i.valid && di_i_ready_o && !flush_i;
    pop  = !empty && di_o_ready_i && !flush_i;
  end

  fifo_ptrs #(.DEPTH(DEPTH)) u_ptrs (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .clear  (flush_i),
    .rd_ptr (rd_ptr),
    .wr_ptr (wr_ptr),
    .count  (count_o),
    .full   (full),
    .empty  (empty)
  );

  // Entry storage; contents are never cleared, only invalidated by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= di_i;
  end

  // Head entry straight from storage; valid reflects occupancy.
  always_comb begin
    di_o       = mem[rd_ptr];
    di_o.valid = !empty;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= DIQ_RUN;
    else     state_q <= state_d;
  end

  // FSM next state: a stored faulting entry holds the queue until flush.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = DIQ_RUN;
    end else begin
      case (state_q)
        DIQ_RUN:  if (push && di_i.fault) state_d = DIQ_HOLD;
        DIQ_HOLD: state_d = DIQ_HOLD;
        default:  state_d = DIQ_RUN;
      endcase
    end
  end

  // FSM outputs: acceptance ignores the downstream pop, so a full queue refuses.
  always_comb begin
    di_i_ready_o = (state_q == DIQ_RUN) && !full;
    fault_hold_o = (state_q == DIQ_HOLD);
  end

  // Id continuity check; the first push after reset/flush only seeds the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_err_o <= 1'b0;
      resync    <= 1'b1;
      exp_id    <= '0;
    end else if (flush_i) begin
      resync    <= 1'b1;
    end else if (push) begin
      resync <= 1'b0;
      if (!resync && (di_i.id[ID_W-1:0] != exp_id)) seq_err_o <= 1'b1;
      exp_id <= di_i.id[ID_W-1:0] + 1'b1;
    end
  end

endmodule

// File: tb/tb_di_queue.sv
// Directed bench for di_queue with a queue-based reference model.
module tb_di_queue;
  import C::*;

  localparam int unsigned DEPTH = 8;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       o_rdy;
  di_t        di_i;
  di_t        di_o;
  logic       i_rdy;
  logic [3:0] count;
  logic       hold;
  logic       seq_err;

  di_queue #(.DEPTH(DEPTH), .ID_W(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .di_i         (di_i),
    .di_i_ready_o (i_rdy),
    .di_o         (di_o),
    .di_o_ready_i (o_rdy),
    .flush_i      (flush),
    .count_o      (count),
    .fault_hold_o (hold),
    .seq_err_o    (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-order queue of {fault,id}, hold flag, id expectation.
  logic [20:0] m_q[$];
  bit          m_hold;
  bit          m_seq;
  bit          m_resync;
  int unsigned m_exp;
  bit          started = 0;

  always @(posedge clk) begin
    bit can_take;
    can_take = !m_hold && (m_q.size() < DEPTH);
    if (rst) begin
      m_q.delete();
      m_hold = 0; m_seq = 0; m_resync = 1; m_exp = 0;
      started = 1;
    end else if (flush) begin
      m_q.delete();
      m_hold = 0; m_resync = 1;
    end else begin
      if (m_q.size() > 0 && o_rdy) void'(m_q.pop_front());
      if (di_i.valid && can_take) begin
        m_q.push_back({di_i.fault, di_i.id});
        if (di_i.fault) m_hold = 1;
        if (m_resync) m_resync = 0;
        else if (int'(di_i.id) != m_exp) m_seq = 1;
        m_exp = (int'(di_i.id) + 1) % (1 << 20);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("count", 32'(count), 32'(m_q.size()));
      chk("in_ready", 32'(i_rdy), 32'(!m_hold && m_q.size() < DEPTH));
      chk("out_valid", 32'(di_o.valid), 32'(m_q.size() > 0));
      chk("fault_hold", 32'(hold), 32'(m_hold));
      chk("seq_err", 32'(seq_err), 32'(m_seq));
      if (m_q.size() > 0) begin
        chk("head_id", 32'(di_o.id), 32'(m_q[0][19:0]));
        chk("head_fault", 32'(di_o.fault), 32'(m_q[0][20]));
      end
    end
  end

  // One cycle of stimulus; returns 1 time unit after the edge.
  task automatic cyc(input logic v, input logic f, input int id, input logic rd,
                     input logic fl = 1'b0, input logic r = 1'b0);
    di_i.valid   = v;
    di_i.fault   = f;
    di_i.id      = 20'(id);
    di_i.payload = 32'(id * 3);
    o_rdy = rd;
    flush = fl;
    rst   = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    di_i = '0; o_rdy = 0; flush = 0; rst = 1;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(i_rdy), 1);
    chk("rst_valid", 32'(di_o.valid), 0);
    chk("rst_hold", 32'(hold), 0);

    // 1: push 0..3 with issue stalled
    for (int i = 0; i < 4; i++) cyc(1, 0, i, 0);
    chk("t1_count", 32'(count), 4);
    chk("t1_head", 32'(di_o.id), 0);
    chk("t1_seq", 32'(seq_err), 0);

    // 2: fill, then push+pop while full
    for (int i = 4; i < 8; i++) cyc(1, 0, i, 0);
    chk("t2_full_count", 32'(count), 8);
    chk("t2_full_ready", 32'(i_rdy), 0);
    chk("t2_head0", 32'(di_o.id), 0);
    cyc(1, 0, 8, 1);
    chk("t2_refused_count", 32'(count), 7);
    for (int i = 1; i < 8; i++) begin
      chk("t2_order", 32'(di_o.id), 32'(i));
      cyc(0, 0, 0, 1);
    end
    chk("t2_empty", 32'(di_o.valid), 0);

    // 3: faulting entry enters HOLD; drains normally; only flush releases
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 5, 0);
    chk("t3_ready", 32'(i_rdy), 0);
    chk("t3_hold", 32'(hold), 1);
    cyc(1, 0, 6, 0);
    chk("t3_count", 32'(count), 1);
    chk("t3_head_id", 32'(di_o.id), 5);
    chk("t3_head_fault", 32'(di_o.fault), 1);
    cyc(0, 0, 0, 1);
    chk("t3_drained", 32'(di_o.valid), 0);
    chk("t3_still_hold", 32'(i_rdy), 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t3_flush_ready", 32'(i_rdy), 1);
    chk("t3_flush_hold", 32'(hold), 0);

    // 4: id gap raises sticky error; flush resyncs; reset clears
    cyc(1, 0, 10, 1);
    cyc(1, 0, 11, 1);
    chk("t4_no_err", 32'(seq_err), 0);
    cyc(1, 0, 13, 1);
    chk("t4_err", 32'(seq_err), 1);
    cyc(0, 0, 0, 0);
    chk("t4_sticky", 32'(seq_err), 1);
    cyc(1, 0, 20, 0, 1);
    cyc(1, 0, 40, 0);
    cyc(1, 0, 41, 0);
    chk("t4_after_flush", 32'(seq_err), 1);
    cyc(0, 0, 0, 0, 1, 1);
    chk("t4_rst_clear", 32'(seq_err), 0);
    chk("t4_rst_count", 32'(count), 0);

    // 5: id wrap is continuous
    cyc(1, 0, (1 << 20) - 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    chk("t5_wrap", 32'(seq_err), 0);
    chk("t5_count", 32'(count), 3);

    // 6: flush beats simultaneous push and pop
    cyc(1, 0, 2, 1, 1);
    chk("t6_count", 32'(count), 0);
    chk("t6_valid", 32'(di_o.valid), 0);
    cyc(0, 0, 0, 0);
    chk("t6_still_empty", 32'(di_o.valid), 0);
    cyc(1, 0, 77, 0);
    chk("t6_new_head", 32'(di_o.id), 77);
    chk("t6_new_count", 32'(count), 1);
    chk("t6_seq", 32'(seq_err), 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
